// File: rtl/match_ctrl_pkg.sv
// Shared types and constants for the match controller and its frame timer.
package match_pkg;

    localparam int SCORE_W = 4;
    localparam int CNT_W   = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        PAUSE     = 3'd3,
        POINT     = 3'd4,
        RESYNC    = 3'd5,
        MATCH_END = 3'd6
    } state_e;

    localparam logic [1:0] P_NONE = 2'd0;
    localparam logic [1:0] P1     = 2'd1;
    localparam logic [1:0] P2     = 2'd2;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/match_ctrl_if.sv
// Bundle between match controller, physics engine, buttons and HUD.
interface match_ctrl_if;
    import match_pkg::*;

    logic               frame_tick;
    logic               start_btn;
    logic               pause_btn;
    logic               game_over;
    logic [1:0]         winner;
    logic               phys_en;
    logic [SCORE_W-1:0] p1_score;
    logic [SCORE_W-1:0] p2_score;
    logic [2:0]         match_state;
    logic [1:0]         match_winner;
    logic [CNT_W-1:0]   countdown;
    logic               point_pulse;
    logic [1:0]         last_point;

    modport slave (
        input  frame_tick, start_btn, pause_btn, game_over, winner,
        output phys_en, p1_score, p2_score, match_state, match_winner,
               countdown, point_pulse, last_point
    );

    modport master (
        output frame_tick, start_btn, pause_btn, game_over, winner,
        input  phys_en, p1_score, p2_score, match_state, match_winner,
               countdown, point_pulse, last_point
    );

endinterface

// File: rtl/match_ctrl_frame_timer.sv
// Loadable frame down-counter; expire flags the tick that takes it from 1 to 0.
module frame_timer
    import match_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             expire
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (tick && count != '0)
            count <= count - CNT_W'(1);
    end

    assign expire = tick && !load && (count == CNT_W'(1));

endmodule

// File: rtl/match_ctrl.sv
// Match sequencer: scoring, serve/point countdowns and gating of the physics frame enable.
//   state     | meaning
//   IDLE      | waiting for start
//   SERVE     | serve countdown, physics frozen
//   PLAY      | rally running, ticks passed to physics
//   PAUSE     | player pause
//   POINT     | post-point freeze countdown
//   RESYNC    | pass one tick so physics re-centres and drops game_over
//   MATCH_END | winner shown, scores held
module match_ctrl
    import match_pkg::*;
#(
    parameter int WIN_SCORE    = 7,
    parameter int POINT_FRAMES = 90,
    parameter int SERVE_FRAMES = 120
) (
    input logic         clk,
    input logic         rst_n,
    match_ctrl_if.slave bus
);

    state_e             state, state_d;
    logic               start_q, pause_q, go_q;
    logic               start_rise, pause_rise, go_rise;
    logic               clear_scores, clear_meta, award, set_mw;
    logic               load, timer_tick, expire, phys_en_d;
    logic [CNT_W-1:0]   load_val, count;
    logic               phys_en, point_pulse;
    logic [SCORE_W-1:0] p1_score, p2_score;
    logic [1:0]         last_point, match_winner;
    logic               reached_win;

    assign start_rise  = bus.start_btn & ~start_q;
    assign pause_rise  = bus.pause_btn & ~pause_q;
    assign go_rise     = bus.game_over & ~go_q;
    assign reached_win = (p1_score >= SCORE_W'(WIN_SCORE)) || (p2_score >= SCORE_W'(WIN_SCORE));

    frame_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .tick     (timer_tick),
        .count    (count),
        .expire   (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    // Button edges are decoded before the tick; a tick that coincides with a
    // state change is not forwarded to physics.
    always_comb begin
        state_d      = state;
        clear_scores = 1'b0;
        clear_meta   = 1'b0;
        award        = 1'b0;
        set_mw       = 1'b0;
        load         = 1'b0;
        load_val     = CNT_W'(SERVE_FRAMES);
        timer_tick   = 1'b0;
        phys_en_d    = 1'b0;
        case (state)
            IDLE: begin
                if (start_rise) begin
                    clear_scores = 1'b1;
                    clear_meta   = 1'b1;
                    load         = 1'b1;
                    state_d      = SERVE;
                end
            end
            SERVE: begin
                timer_tick = bus.frame_tick;
                if (expire)
                    state_d = PLAY;
            end
            PLAY: begin
                if (go_rise && (bus.winner == P1 || bus.winner == P2)) begin
                    award    = 1'b1;
                    load     = 1'b1;
                    load_val = CNT_W'(POINT_FRAMES);
                    state_d  = POINT;
                end else if (pause_rise) begin
                    state_d = PAUSE;
                end else begin
                    phys_en_d = bus.frame_tick;
                end
            end
            PAUSE: begin
                if (start_rise) begin
                    clear_scores = 1'b1;
                    state_d      = IDLE;
                end else if (pause_rise) begin
                    state_d = PLAY;
                end
            end
            POINT: begin
                timer_tick = bus.frame_tick;
                if (expire) begin
                    if (reached_win) begin
                        set_mw  = 1'b1;
                        state_d = MATCH_END;
                    end else begin
                        state_d = RESYNC;
                    end
                end
            end
            RESYNC: begin
                if (bus.frame_tick) begin
                    phys_en_d = 1'b1;
                    load      = 1'b1;
                    state_d   = SERVE;
                end
            end
            MATCH_END: begin
                if (start_rise) begin
                    clear_scores = 1'b1;
                    clear_meta   = 1'b1;
                    state_d      = RESYNC;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q      <= 1'b0;
            pause_q      <= 1'b0;
            go_q         <= 1'b0;
            phys_en      <= 1'b0;
            point_pulse  <= 1'b0;
            p1_score     <= '0;
            p2_score     <= '0;
            last_point   <= P_NONE;
            match_winner <= P_NONE;
        end else begin
            start_q     <= bus.start_btn;
            pause_q     <= bus.pause_btn;
            go_q        <= bus.game_over;
            phys_en     <= phys_en_d;
            point_pulse <= award;
            if (clear_scores) begin
                p1_score <= '0;
                p2_score <= '0;
            end else if (award) begin
                if (bus.winner == P1)
                    p1_score <= sat_inc(p1_score);
                else
                    p2_score <= sat_inc(p2_score);
            end
            if (clear_meta) begin
                last_point   <= P_NONE;
                match_winner <= P_NONE;
            end else begin
                if (award)
                    last_point <= bus.winner;
                if (set_mw)
                    match_winner <= last_point;
            end
        end
    end

    assign bus.phys_en      = phys_en;
    assign bus.p1_score     = p1_score;
    assign bus.p2_score     = p2_score;
    assign bus.match_state  = state;
    assign bus.match_winner = match_winner;
    assign bus.countdown    = count;
    assign bus.point_pulse  = point_pulse;
    assign bus.last_point   = last_point;

endmodule

// File: tb/tb_match_ctrl.sv
// Directed-sequence bench for match_ctrl with randomized tick spacing and point winners.
module tb_match_ctrl;
    import match_pkg::*;

    localparam int WIN = 7;
    localparam int PF  = 90;
    localparam int SF  = 120;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    match_ctrl_if bus();

    match_ctrl #(.WIN_SCORE(WIN), .POINT_FRAMES(PF), .SERVE_FRAMES(SF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int exp_state, exp_p1, exp_p2, exp_last, exp_mw, exp_cd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".state"}, 32'(bus.match_state), exp_state);
        chk({tag, ".p1"}, 32'(bus.p1_score), exp_p1);
        chk({tag, ".p2"}, 32'(bus.p2_score), exp_p2);
        chk({tag, ".last"}, 32'(bus.last_point), exp_last);
        chk({tag, ".mwin"}, 32'(bus.match_winner), exp_mw);
        chk({tag, ".cd"}, 32'(bus.countdown), exp_cd);
    endtask

    // one frame tick after a random idle gap; returns phys_en one clk later
    task automatic frame(output logic en);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        en = bus.phys_en;
    endtask

    task automatic press_start();
        bus.start_btn = 1'b1;
        @(negedge clk);
        bus.start_btn = 1'b0;
    endtask

    task automatic press_pause();
        bus.pause_btn = 1'b1;
        @(negedge clk);
        bus.pause_btn = 1'b0;
    endtask

    task automatic run_serve();
        logic en;
        for (int i = 0; i < SF; i++) begin
            frame(en);
            chk("serve.en", 32'(en), 0);
            exp_cd    = SF - 1 - i;
            exp_state = (exp_cd == 0) ? PLAY : SERVE;
            chk("serve.cd", 32'(bus.countdown), exp_cd);
            chk("serve.state", 32'(bus.match_state), exp_state);
        end
    endtask

    task automatic play_frames(input int n);
        logic en;
        for (int i = 0; i < n; i++) begin
            frame(en);
            chk("play.en", 32'(en), 1);
            chk("play.state", 32'(bus.match_state), PLAY);
        end
    endtask

    task automatic run_point(input int n);
        logic en;
        for (int i = 0; i < n; i++) begin
            frame(en);
            chk("point.en", 32'(en), 0);
            exp_cd--;
            if (exp_cd == 0) begin
                if (exp_p1 >= WIN || exp_p2 >= WIN) begin
                    exp_state = MATCH_END;
                    exp_mw    = exp_last;
                end else begin
                    exp_state = RESYNC;
                end
            end
            chk_all("point");
        end
    endtask

    task automatic resync();
        logic en;
        frame(en);
        chk("resync.en", 32'(en), 1);
        bus.game_over = 1'b0;
        exp_state = SERVE;
        exp_cd    = SF;
        chk_all("resync");
    endtask

    task automatic score(input int w);
        bus.winner    = 2'(w);
        bus.game_over = 1'b1;
        @(negedge clk);
        if (w == 1) exp_p1 = (exp_p1 < 15) ? exp_p1 + 1 : 15;
        else        exp_p2 = (exp_p2 < 15) ? exp_p2 + 1 : 15;
        exp_last  = w;
        exp_state = POINT;
        exp_cd    = PF;
        chk("score.pulse", 32'(bus.point_pulse), 1);
        chk_all("score");
        @(negedge clk);
        chk("score.pulse_end", 32'(bus.point_pulse), 0);
    endtask

    task automatic fake_go(input int w);
        bus.winner    = 2'(w);
        bus.game_over = 1'b1;
        @(negedge clk);
        chk("nogo.pulse", 32'(bus.point_pulse), 0);
        chk_all("nogo");
        bus.game_over = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_reset(input string tag);
        exp_state = IDLE; exp_p1 = 0; exp_p2 = 0;
        exp_last  = 0;    exp_mw = 0; exp_cd = 0;
        chk_all(tag);
        chk({tag, ".en"}, 32'(bus.phys_en), 0);
        chk({tag, ".pulse"}, 32'(bus.point_pulse), 0);
    endtask

    initial begin
        logic en;
        int   w;
        bus.frame_tick = 1'b0;
        bus.start_btn  = 1'b0;
        bus.pause_btn  = 1'b0;
        bus.game_over  = 1'b0;
        bus.winner     = 2'd0;
        repeat (3) @(negedge clk);
        expect_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);
        frame(en);
        chk("idle.en", 32'(en), 0);

        press_start();
        exp_state = SERVE; exp_cd = SF;
        chk_all("start");
        run_serve();
        play_frames($urandom_range(3, 6));
        press_start();
        chk_all("start_in_play");
        fake_go(0);

        // game_over stays high for the whole POINT window
        score(2);
        run_point(PF);
        resync();
        run_serve();

        while (exp_state != MATCH_END) begin
            play_frames($urandom_range(1, 4));
            if ($urandom_range(0, 3) == 0) fake_go(($urandom_range(0, 1) == 0) ? 0 : 3);
            w = (exp_p2 < 5 && $urandom_range(0, 2) == 0) ? 2 : 1;
            score(w);
            run_point(PF);
            if (exp_state == RESYNC) begin
                resync();
                run_serve();
            end
        end
        chk("end.mwin", 32'(bus.match_winner), 1);
        chk("end.p1", 32'(bus.p1_score), WIN);
        for (int i = 0; i < 5; i++) begin
            frame(en);
            chk("end.en", 32'(en), 0);
        end
        press_start();
        exp_p1 = 0; exp_p2 = 0; exp_last = 0; exp_mw = 0; exp_cd = 0;
        exp_state = RESYNC;
        chk_all("restart");
        resync();
        run_serve();

        press_pause();
        exp_state = PAUSE;
        chk_all("pause");
        for (int i = 0; i < 200; i++) begin
            frame(en);
            chk("pause.en", 32'(en), 0);
        end
        chk_all("pause_hold");
        press_pause();
        exp_state = PLAY;
        chk_all("unpause");
        play_frames(3);

        // point and pause edges in the same clk: point wins
        bus.winner    = 2'd2;
        bus.game_over = 1'b1;
        bus.pause_btn = 1'b1;
        @(negedge clk);
        bus.pause_btn = 1'b0;
        exp_p2 = 1; exp_last = 2; exp_state = POINT; exp_cd = PF;
        chk("both.pulse", 32'(bus.point_pulse), 1);
        chk_all("both");
        run_point(PF - 40);
        chk("mid.cd", 32'(bus.countdown), 40);
        #1 rst_n = 1'b0;
        #1 expect_reset("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        bus.game_over = 1'b0;
        bus.winner    = 2'd0;
        @(negedge clk);

        press_start();
        exp_state = SERVE; exp_cd = SF;
        chk_all("start2");
        run_serve();
        fake_go(0);
        play_frames(2);
        score(1);
        run_point(PF);
        resync();
        run_serve();
        press_pause();
        exp_state = PAUSE;
        chk_all("pause2");
        press_start();
        exp_state = IDLE; exp_p1 = 0; exp_p2 = 0;
        chk_all("pause_quit");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/match_ctrl.md
Name: match_ctrl

Overview:
- Downstream of the physics engine: consumes its end-of-rally signals (`game_over`, `winner`), keeps the score and runs the match state machine.
- Gates the 60 Hz frame tick into the physics engine's `en` input, which provides serve delays, point pauses, player pause and match end.
- Feeds score, state and countdown to the video/HUD stage.

Parameters:
- WIN_SCORE, 7, points needed to win the match (1..15).
- POINT_FRAMES, 90, frames the scene stays frozen after a point (1..255).
- SERVE_FRAMES, 120, frames of countdown before play resumes (1..255).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-clk pulse at 60 Hz
- start_btn  in  1  debounced, synchronous level; rising edge starts/restarts a match
- pause_btn  in  1  debounced, synchronous level; rising edge toggles pause
- game_over  in  1  physics rally-end flag (level; cleared by physics on its next en)
- winner  in  2  physics rally winner: 1 = P1, 2 = P2, 0/3 = none
- phys_en  out  1  gated frame enable to physics (registered one-clk pulse)
- p1_score  out  4  P1 points
- p2_score  out  4  P2 points
- match_state  out  3  current FSM state (package encoding)
- match_winner  out  2  0 = none, 1 = P1, 2 = P2; valid in MATCH_END
- countdown  out  8  frames remaining in POINT/SERVE, else 0
- point_pulse  out  1  one-clk pulse when a point is awarded
- last_point  out  2  winner of the most recent point (0 after reset/new match)

Behaviour:
- Reset values: state IDLE; all outputs 0.
- Internal registers: start_q, pause_q and go_q are 1-cycle delayed copies.
  - start_rise = start_btn & ~start_q; pause_rise and go_rise are formed the same way.
  - go_q updates every clk in every state.
- phys_en is registered. It equals frame_tick delayed one clk and is asserted only when:
  - the state is PLAY, or
  - the state is RESYNC and the tick is the first one seen there.
- IDLE:
  - phys_en 0.
  - start_rise → clear scores, last_point and match_winner; countdown := SERVE_FRAMES; go to SERVE.
- SERVE:
  - phys_en 0.
  - Each frame_tick decrements countdown.
  - A tick when countdown == 1 → countdown := 0; go to PLAY.
- PLAY: phys_en follows frame_tick.
  - go_rise with winner == 1 or 2:
    - increment that player's score (saturate at 15);
    - last_point := winner;
    - point_pulse = 1 for that clk;
    - countdown := POINT_FRAMES; go to POINT.
  - go_rise with winner 0/3 → ignored; stay in PLAY.
  - pause_rise (without go_rise) → PAUSE.
  - Simultaneous go_rise and pause_rise: the point wins and the pause is dropped.
- PAUSE:
  - phys_en 0.
  - pause_rise → PLAY.
  - start_rise → IDLE with scores cleared.
- POINT:
  - phys_en 0.
  - Each frame_tick decrements countdown.
  - At expiry (tick while countdown == 1):
    - if p1_score or p2_score ≥ WIN_SCORE → match_winner := scorer; MATCH_END;
    - else → RESYNC.
- RESYNC:
  - Passes exactly one frame_tick to phys_en so physics resets positions and clears game_over.
  - On that tick: countdown := SERVE_FRAMES; go to SERVE.
  - go_rise is never generated here, because game_over falls.
- MATCH_END:
  - phys_en 0; scores are held.
  - start_rise → clear scores, last_point and match_winner; go to RESYNC.
- General rules:
  - start_rise in SERVE, PLAY or POINT is ignored.
  - A frame_tick and a button edge in the same clk: the edge is evaluated first (state change), and the tick is applied in the new state next time.
  - frame_tick is never lost in counting: the countdown decrements only on ticks.
  - Reset asserted mid-operation returns everything to reset values immediately; no pulse is emitted.

Decomposition:
- Shared package `match_pkg`:
  - state enum: IDLE = 0, SERVE = 1, PLAY = 2, PAUSE = 3, POINT = 4, RESYNC = 5, MATCH_END = 6;
  - SCORE_W = 4; CNT_W = 8;
  - player codes P_NONE = 0, P1 = 1, P2 = 2.
- Sub-module `frame_timer`: loadable CNT_W down-counter.
  - Inputs: load, load_val, tick.
  - Outputs: count, expire.
  - Instantiated once; shared between POINT and SERVE.

Test Plan:
- Reset, then start_btn rise → SERVE with countdown 120. After 120 frame_ticks → PLAY; phys_en pulses 1 clk after each tick from then on.
- In PLAY, game_over rises with winner = 2 → p2_score 0→1, one-clk point_pulse, last_point = 2, POINT with countdown 90, phys_en silent for 90 ticks. Then RESYNC with exactly one phys_en pulse, then SERVE 120.
- game_over held high across POINT (never cleared) → no second point awarded; score stays 1.
- P1 scores 7 points (WIN_SCORE = 7) → after the 7th POINT countdown: MATCH_END, match_winner = 1, p1_score = 7, phys_en 0. start_btn rise → scores 0, RESYNC pulse, then SERVE.
- In PLAY, pause_btn rise → PAUSE, no phys_en for 200 ticks; second rise → PLAY. go_rise and pause_rise in the same clk → point awarded, state POINT, not PAUSE.
- rst_n asserted mid-POINT with countdown 40 → all outputs 0 and IDLE. winner = 0 with go_rise → no score change, stays PLAY.
